// File: rtl/dev_hex_loader.sv
// rtl/dev_hex_loader.sv - ASCII hex stream to RAM loader; optional checksum terminator under DEV_HEX_LOADER_CHECKSUM_EN

package pkg_ram;
   localparam int RAM_ADDRW = 32;
   localparam int RAM_BYTE  = 8;
   localparam int RAM_WORD  = 16;
   localparam int RAM_LONG  = 32;
   localparam int RAM_QUAD  = 64;
   localparam int RAM_SIZEW = 7;

   typedef enum logic [1:0] {
      RAM_NOP   = 2'd0,
      RAM_LOAD  = 2'd1,
      RAM_STORE = 2'd2
   } ram_op_t;
endpackage

interface if_dev_ram;
   import pkg_ram::*;
   ram_op_t                op;
   logic [RAM_ADDRW-1:0]   addr;
   logic [RAM_SIZEW-1:0]   size;
   logic [RAM_QUAD-1:0]    data_in;

   modport master (output op, addr, size, data_in);
   modport slave  (input  op, addr, size, data_in);
endinterface

module dev_hex_loader #(
   parameter int                             WORD_BYTES  = 1,
   parameter logic [pkg_ram::RAM_ADDRW-1:0]  START_ADDR  = '0,
   parameter int                             ADDR_DIGITS = pkg_ram::RAM_ADDRW / 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [pkg_ram::RAM_BYTE-1:0]    data_in,
   input  logic                            data_en,
   if_dev_ram.master                       ram,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [pkg_ram::RAM_ADDRW-1:0]   byte_count
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
   ,
   output logic [pkg_ram::RAM_BYTE-1:0]    checksum
`endif
);
   import pkg_ram::*;

   localparam int AW  = RAM_ADDRW;
   localparam int QW  = RAM_QUAD;
   localparam int WB8 = WORD_BYTES * 8;
   localparam int PW  = $clog2(WORD_BYTES + 1);
   localparam int DW  = $clog2(ADDR_DIGITS + 1);

   localparam logic [RAM_SIZEW-1:0] BYTE_SIZE = RAM_SIZEW'(RAM_BYTE);
   localparam logic [RAM_SIZEW-1:0] WORD_SIZE =
      (WORD_BYTES == 1) ? RAM_SIZEW'(RAM_BYTE) :
      (WORD_BYTES == 2) ? RAM_SIZEW'(RAM_WORD) :
      (WORD_BYTES == 4) ? RAM_SIZEW'(RAM_LONG) : RAM_SIZEW'(RAM_QUAD);

   localparam logic [7:0] CH_EOT  = 8'h04;
   localparam logic [7:0] CH_TAB  = 8'h09;
   localparam logic [7:0] CH_LF   = 8'h0A;
   localparam logic [7:0] CH_CR   = 8'h0D;
   localparam logic [7:0] CH_SP   = 8'h20;
   localparam logic [7:0] CH_HASH = 8'h23;
   localparam logic [7:0] CH_AT   = 8'h40;
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
   localparam logic [7:0] CH_BANG = 8'h21;
`endif

   typedef enum logic [2:0] {
      S_DATA,
      S_ADDR,
      S_COMMENT,
      S_FLUSH,
      S_DONE
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
      ,
      S_CHECK
`endif
   } state_t;

   state_t              state_q;
   state_t              ret_q;
   logic [AW-1:0]       addr_next_q;
   logic                phase_q;
   logic [3:0]          hi_q;
   logic [WB8-1:0]      word_q;
   logic [PW-1:0]       pend_q;
   logic [AW-1:0]       acc_q;
   logic [DW-1:0]       dig_q;
   ram_op_t             op_q;
   logic [AW-1:0]       addr_q;
   logic [RAM_SIZEW-1:0] size_q;
   logic [QW-1:0]       data_q;
   logic                err_q;
   logic [AW-1:0]       cnt_q;
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
   logic [7:0]          cks_q;
   logic [7:0]          word_sum;
`endif

   logic                is_hex;
   logic                is_ws;
   logic [3:0]          nib;
   logic [7:0]          byte_d;
   logic [WB8-1:0]      word_d;
   logic [PW-1:0]       pend_inc;
   logic                word_full;
   logic [7:0]          flush_byte;
   logic [AW-1:0]       acc_d;

   // Classify the incoming character and decode its nibble value
   always_comb begin
      is_hex = 1'b0;
      nib    = 4'h0;
      if (data_in >= 8'h30 && data_in <= 8'h39) begin
         is_hex = 1'b1;
         nib    = data_in[3:0];
      end else if ((data_in >= 8'h41 && data_in <= 8'h46) ||
                   (data_in >= 8'h61 && data_in <= 8'h66)) begin
         is_hex = 1'b1;
         nib    = data_in[3:0] + 4'd9;
      end
      is_ws = (data_in == CH_SP) || (data_in == CH_TAB) ||
              (data_in == CH_CR) || (data_in == CH_LF);
   end

   // Byte assembly, word shifting, flush byte selection and address accumulation
   always_comb begin
      byte_d     = {hi_q, nib};
      word_d     = WB8'({word_q, byte_d});
      pend_inc   = pend_q + PW'(1);
      word_full  = (pend_inc == PW'(WORD_BYTES));
      // Pending bytes sit in the low end of word_q; the oldest is the highest of them
      flush_byte = 8'(word_q >> {pend_q - PW'(1), 3'b000});
      acc_d      = {acc_q[AW-5:0], nib};
   end

`ifdef DEV_HEX_LOADER_CHECKSUM_EN
   // Modulo-256 sum of the bytes of the word about to be stored
   always_comb begin
      word_sum = 8'h00;
      for (int i = 0; i < WORD_BYTES; i++) begin
         word_sum = word_sum + word_d[i*8 +: 8];
      end
   end
`endif

   // Loader FSM: parse characters, assemble words, issue stores, track status
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_DATA;
         ret_q       <= S_DATA;
         addr_next_q <= START_ADDR;
         phase_q     <= 1'b0;
         hi_q        <= 4'h0;
         word_q      <= '0;
         pend_q      <= '0;
         acc_q       <= '0;
         dig_q       <= '0;
         op_q        <= RAM_NOP;
         addr_q      <= '0;
         size_q      <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
         cks_q       <= 8'h00;
`endif
      end else begin
         op_q <= RAM_NOP;
         case (state_q)
            S_DATA: begin
               if (data_en) begin
                  if (is_hex) begin
                     if (!phase_q) begin
                        hi_q    <= nib;
                        phase_q <= 1'b1;
                     end else begin
                        phase_q <= 1'b0;
                        if (word_full) begin
                           op_q        <= RAM_STORE;
                           addr_q      <= addr_next_q;
                           size_q      <= WORD_SIZE;
                           data_q      <= QW'(word_d);
                           addr_next_q <= addr_next_q + AW'(WORD_BYTES);
                           cnt_q       <= cnt_q + AW'(WORD_BYTES);
                           pend_q      <= '0;
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
                           cks_q       <= cks_q + word_sum;
`endif
                        end else begin
                           word_q <= word_d;
                           pend_q <= pend_inc;
                        end
                     end
                  end else begin
                     // A byte never spans a non-hex character; drop the lone nibble
                     phase_q <= 1'b0;
                     if (phase_q) begin
                        err_q <= 1'b1;
                     end
                     if (is_ws) begin
                        state_q <= S_DATA;
                     end else if (data_in == CH_HASH) begin
                        state_q <= S_COMMENT;
                     end else if (data_in == CH_AT) begin
                        state_q <= S_FLUSH;
                        ret_q   <= S_ADDR;
                     end else if (data_in == CH_EOT) begin
                        state_q <= S_FLUSH;
                        ret_q   <= S_DONE;
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
                     end else if (data_in == CH_BANG) begin
                        state_q <= S_FLUSH;
                        ret_q   <= S_CHECK;
`endif
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
            end

            S_ADDR: begin
               if (data_en) begin
                  if (is_hex) begin
                     if (dig_q < DW'(ADDR_DIGITS)) begin
                        acc_q <= acc_d;
                        dig_q <= dig_q + DW'(1);
                     end else begin
                        err_q <= 1'b1;
                     end
                  end else if (is_ws) begin
                     if (dig_q != '0) begin
                        addr_next_q <= acc_q;
                     end else begin
                        err_q <= 1'b1;
                     end
                     state_q <= S_DATA;
                  end else if (data_in == CH_EOT) begin
                     // Nothing is pending here: the directive already flushed
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_DATA;
                  end
               end
            end

            S_COMMENT: begin
               if (data_en) begin
                  if (data_in == CH_LF) begin
                     state_q <= S_DATA;
                  end else if (data_in == CH_EOT) begin
                     state_q <= S_FLUSH;
                     ret_q   <= S_DONE;
                  end
               end
            end

            S_FLUSH: begin
               if (data_en) begin
                  err_q <= 1'b1;
               end
               if (pend_q != '0) begin
                  op_q        <= RAM_STORE;
                  addr_q      <= addr_next_q;
                  size_q      <= BYTE_SIZE;
                  data_q      <= QW'(flush_byte);
                  addr_next_q <= addr_next_q + AW'(1);
                  cnt_q       <= cnt_q + AW'(1);
                  pend_q      <= pend_q - PW'(1);
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
                  cks_q       <= cks_q + flush_byte;
`endif
               end
               if (pend_q <= PW'(1)) begin
                  state_q <= ret_q;
                  acc_q   <= '0;
                  dig_q   <= '0;
                  phase_q <= 1'b0;
               end
            end

`ifdef DEV_HEX_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (data_en) begin
                  if (is_hex && !phase_q) begin
                     hi_q    <= nib;
                     phase_q <= 1'b1;
                  end else begin
                     if (!is_hex || (byte_d != cks_q)) begin
                        err_q <= 1'b1;
                     end
                     phase_q <= 1'b0;
                     state_q <= S_FLUSH;
                     ret_q   <= S_DONE;
                  end
               end
            end
`endif

            S_DONE: begin
               state_q <= S_DONE;
            end

            default: begin
               state_q <= S_DATA;
            end
         endcase
      end
   end

   assign ram.op      = op_q;
   assign ram.addr    = addr_q;
   assign ram.size    = size_q;
   assign ram.data_in = data_q;
   assign busy        = (state_q == S_FLUSH);
   assign done        = (state_q == S_DONE);
   assign error       = err_q;
   assign byte_count  = cnt_q;
`ifdef DEV_HEX_LOADER_CHECKSUM_EN
   assign checksum    = cks_q;
`endif

endmodule

// File: doc/dev_hex_loader.md
Name: dev_hex_loader

Overview:
- Parametrised successor to the byte-wise hex loader.
- Parses an ASCII hex stream from the UART/host character source and writes the decoded bytes into RAM through if_dev_ram. Bytes are grouped into WORD_BYTES-wide stores.
- Adds an '@' address directive, '#' line comments, flushing of partial words, error reporting and a byte counter.
- Sits between the character receiver and the RAM arbiter. It runs before the CPU is released from reset.

Parameters:
- WORD_BYTES, 1, bytes per full store; legal values 1/2/4/8; sets ram.size (RAM_BYTE/WORD/LONG/QUAD).
- START_ADDR, 0, load address after reset.
- ADDR_DIGITS, pkg_ram::RAM_ADDRW/4, maximum hex digits accepted after '@'.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- data_in  input  pkg_ram::RAM_BYTE  received ASCII character.
- data_en  input  1  data_in valid strobe; at most one character per cycle.
- ram  output  if_dev_ram  op/addr/size/data_in toward RAM; one-cycle RAM_STORE pulses.
- busy  output  1  high in FLUSH; characters with data_en high during busy are dropped and set error.
- done  output  1  load finished (EOT 0x04 received and flushed); sticky until reset.
- error  output  1  sticky protocol error.
- byte_count  output  pkg_ram::RAM_ADDRW  bytes written since reset.

Behaviour:
- Reset (rst==0 at posedge):
  - state=DATA, addr_next=START_ADDR, nibble phase=0, pending byte count=0.
  - ram.op=RAM_NOP, ram.addr=0, ram.data_in=0.
  - done=0, error=0, busy=0, byte_count=0.
  - Reset mid-load discards all pending bytes; no store is issued.
- Character classes:
  - hex digit: 0-9, A-F, a-f.
  - whitespace: space, \t, \r, \n.
  - '@' address directive; '#' comment; 0x04 end of transmission (EOT).
  - Any other character sets error and is otherwise ignored.
- States: DATA, ADDR, COMMENT, FLUSH, DONE.
- DATA state:
  - Hex digits pair high/low into bytes.
  - Each completed byte is shifted into the word buffer. The first byte in text order lands in the most significant byte (big-endian, ULM order).
  - When WORD_BYTES bytes are pending, ram.op=RAM_STORE on the next cycle. ram.addr=addr_next; addr_next += WORD_BYTES; byte_count += WORD_BYTES.
  - Latency: last digit accepted at cycle N -> store visible at cycle N+1.
  - Whitespace is ignored; a byte may not span whitespace. A lone high nibble followed by a non-hex character sets error and the nibble is discarded.
  - '#' -> COMMENT. '@' -> FLUSH with return target ADDR. EOT -> FLUSH with return target DONE.
- ADDR state:
  - Hex digits shift into an address accumulator, reset to 0 on entry.
  - More than ADDR_DIGITS digits sets error; extra digits are ignored.
  - Whitespace with at least 1 digit -> addr_next=accumulator, go to DATA.
  - Whitespace with 0 digits, any other character, or EOT sets error and returns to DATA, addr_next unchanged. EOT then additionally goes to DONE.
- COMMENT state: discard all characters until \n -> DATA; EOT -> FLUSH/DONE.
- FLUSH state:
  - busy=1.
  - Issues one RAM_BYTE store per cycle for each pending byte, in text order, at addr_next, addr_next+1, ...
  - Each flush store increments addr_next and byte_count by 1.
  - With 0 pending bytes, FLUSH lasts exactly 1 cycle with no store.
  - Then proceeds to the return target.
- ram.size: equals the WORD_BYTES size for full-word stores and RAM_BYTE for flush stores. ram.data_in is zero-extended to RAM_QUAD.
- DONE state: done=1, all input ignored, ram.op=RAM_NOP.
- Wrap-around: addr_next wraps modulo 2^RAM_ADDRW and byte_count wraps silently. Unaligned addresses are not checked; WORD stores go to addr_next as is.
- The hex-digit completion and the store of the previous word cannot collide, because input is at most one character per cycle and a store takes one cycle.

Optional Feature:
- Macro: DEV_HEX_LOADER_CHECKSUM_EN.
- With the macro:
  - Extra output checksum [pkg_ram::RAM_BYTE-1:0], the 8-bit modulo-256 sum of every byte written to RAM; reset to 0.
  - A second EOT-like terminator '!' followed by two hex digits compares those digits with checksum. A mismatch sets error, then the block enters DONE via FLUSH.
- Without the macro: no checksum port or logic, and '!' is an illegal character (sets error).

Test Plan:
- WORD_BYTES=1, stream "4A 0b" + 0x04 -> stores 0x4A@0 then 0x0B@1 at size RAM_BYTE, each 1 cycle after its second digit; done=1, byte_count=2, error=0.
- WORD_BYTES=4, "01020304 0506" + EOT -> one LONG store 0x01020304@0; FLUSH emits byte stores 0x05@4 and 0x06@5 with busy=1 for 2 cycles; byte_count=6.
- "@100 FF # zz\n EE" + EOT (WORD_BYTES=1) -> stores 0xFF@0x100 and 0xEE@0x101; comment text ignored, error=0.
- "4G" then "A" + EOT -> error=1, no store for 4G; 'A' alone leaves a half byte, so no store; done=1.
- rst=0 asserted between the two digits of "7C" -> no store occurs; after release "7C" stores 0x7C@START_ADDR.
- With DEV_HEX_LOADER_CHECKSUM_EN: "FF 02 !01" -> checksum=0x01, error=0, done=1; "FF 02 !00" -> error=1, done=1.
